snake_engine: RTL and testbench
===============================

# snake_engine

Parametrised snake body engine: it advances the snake one grid cell per game tick, and handles growth, wall or wrap-around, and self-collision. It replaces the fixed 32×24, 64-segment snake mover. It sits between the `direction` and `fsm` blocks and feeds the `food`, `score` and VGA render paths. It adds three things: configurable grid and length, a torus (wrap) mode, and a multi-cycle serial self-collision scan that scales with `MAX_LEN`.

## Interface
- `GRID_W`, 32: grid columns; `XW = $clog2(GRID_W)`.
- `GRID_H`, 24: grid rows; `YW = $clog2(GRID_H)`.
- `MAX_LEN`, 64: maximum segment count.
- `INIT_LEN`, 3: length after reset or INITIAL; must be at least 2 and at most `MAX_LEN`.
- `INIT_X`, 10 / `INIT_Y`, 12: head cell after reset.
- `WRAP`, 0: 0 means a wall ends the game; 1 means the head wraps around the grid edges.
- `TICK_DIV`, 12_500_000: `clk` cycles per step at normal speed.
- `SLOW_MUL`, 2: step-period multiplier while `slow` is high.

Ports (one synchronous clock domain):
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `game_state` in 2: RUNNING=00, DIE=01, INITIAL=10.
- `next_direction` in 2: UP=00, DOWN=01, RIGHT=10, LEFT=11.
- `pause` in 1: freezes the tick counter.
- `slow` in 1: stretches the step period.
- `food_x` in XW / `food_y` in YW: food cell.
- `snake_x_1dim` out MAX_LEN*XW: segment i at bits [i*XW +: XW]; index 0 is the head.
- `snake_y_1dim` out MAX_LEN*YW: same layout for y.
- `snake_length` out $clog2(MAX_LEN+1): current length.
- `current_direction` out 2: direction committed on the last step.
- `get_food` out 1: one-cycle pulse when food is eaten.
- `hit_boundary` out 1 / `hit_self` out 1: sticky collision flags.
- `busy` out 1: high while a step is in flight (CALC, SCAN or MOVE).

## Operation
- **FSM states:** IDLE, CALC, SCAN, MOVE, DEAD.
- **Reset, or `game_state`=INITIAL (any state):**
  - go to IDLE; body is segment i = (INIT_X−i, INIT_Y) for i < INIT_LEN, all other segments are 0;
  - length = INIT_LEN; `current_direction`=RIGHT; flags, `get_food` and the tick counter are cleared.
- **IDLE:**
  - the tick counter runs only when `game_state`=RUNNING and `pause`=0;
  - terminal count is TICK_DIV−1, or TICK_DIV*SLOW_MUL−1 when `slow`=1;
  - when the counter hits terminal count it wraps to 0 and the FSM goes to CALC.
- **CALC (1 cycle):**
  - latch the direction: if `next_direction` is the exact reverse of `current_direction`, keep `current_direction`; otherwise take `next_direction`;
  - compute the candidate head as the current head ±1 on one axis;
  - WRAP=0 and the step leaves the grid: set `hit_boundary` and go to DEAD;
  - WRAP=1: x wraps between 0 and GRID_W−1, y wraps between 0 and GRID_H−1;
  - sample `grow = (cand == food)`.
- **SCAN (serial, one segment per cycle):**
  - compare the candidate with segment i, for i = 0 … L−2 when `grow`=0 (the tail vacates its cell) or i = 0 … L−1 when `grow`=1;
  - on a match: set `hit_self` and go to DEAD; otherwise go to MOVE after the last index.
- **MOVE (1 cycle):**
  - shift segments i ← i−1 and write the candidate into segment 0; commit `current_direction`;
  - if `grow`: pulse `get_food`; length increments, saturating at MAX_LEN;
  - `grow` at MAX_LEN still pulses `get_food`, but the tail is dropped;
  - return to IDLE.
- **DEAD:** holds body and flags until INITIAL or `rst`.
- `game_state`=DIE while a step is in flight: the step completes, then the FSM stays in IDLE (no tick).
- `pause` asserted mid-step: the step completes, and the counter freezes from then on.

## Timing
- Step latency from tick to committed body is L+1 cycles when `grow`=0 and L+2 when `grow`=1 (1 CALC + scan + 1 MOVE). Example: L=3, no food → CALC, SCAN×2, MOVE = 4 cycles.
- `busy` is high from CALC through MOVE inclusive.
- All outputs are registered. Body, length and direction update in the cycle after MOVE.
- `get_food` is high for exactly one cycle, coincident with the body update.
- Collision flags assert in the cycle after CALC or the matching SCAN cycle, and stay set.
- Required: TICK_DIV > MAX_LEN+2, so a step always finishes before the next tick. This is checked by an elaboration-time assertion.

## Structure
- Shared package `snake_pkg`:
  - direction codes, `game_state` codes;
  - `dir_reverse()` function;
  - width helpers for XW and YW.
- One natural sub-module: `snake_tick_gen` (tick counter with pause and slow handling).
- FSM, scan index and body shift register stay in `snake_engine`.

## Test plan
- **Reset:** `rst` 1 cycle with defaults → length 3; head (10,12), then (9,12), (8,12); direction RIGHT; `busy`=0; flags 0.
- **Straight run:** TICK_DIV=8, RUNNING, no input → head (11,12) committed exactly 8+4 cycles after reset release.
- **Reverse rejection:** heading RIGHT, `next_direction`=LEFT → head moves to (11,12) and direction stays RIGHT.
- **Growth:** food at (11,12) → `get_food` one-cycle pulse, length 4, tail (8,12) kept.
- **Growth at MAX_LEN** (MAX_LEN=4 at length 4) → `get_food` pulses and length stays 4.
- **Walls:**
  - WRAP=0, head (31,5) moving RIGHT → `hit_boundary`=1, DEAD, body unchanged;
  - WRAP=1, same start → head (0,5), no flag.
- **Self-hit, tail-chase and reset:**
  - hand-built length-5 loop, head turns into segment 3 → `hit_self`;
  - turning into the tail cell with no food → no hit;
  - `rst` mid-SCAN → initial body next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared codes and helpers for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    GS_RUNNING = 2'b00,
    GS_DIE     = 2'b01,
    GS_INITIAL = 2'b10
  } gstate_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_MOVE,
    S_DEAD
  } state_e;

  // UP<->DOWN and RIGHT<->LEFT differ only in bit 0.
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int coord_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Step-rate divider: counts only while enabled, stretches the period when slow.
module snake_tick_gen
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int SLOW_MUL = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic slow_i,
  output logic tick_o
);

  localparam int CW = coord_w(TICK_DIV * SLOW_MUL);

  logic [CW-1:0] cnt_q, cnt_d, tc;

  // >= rather than == so a slow->fast switch above the new limit still ticks.
  always_comb begin
    tc     = slow_i ? CW'(TICK_DIV * SLOW_MUL - 1) : CW'(TICK_DIV - 1);
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (en_i) begin
      if (cnt_q >= tc) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: one-cell step per tick with growth, walls/wrap and a
// serial self-collision scan over the body.
module snake_engine
  import snake_pkg::*;
#(
  parameter  int GRID_W   = 32,
  parameter  int GRID_H   = 24,
  parameter  int MAX_LEN  = 64,
  parameter  int INIT_LEN = 3,
  parameter  int INIT_X   = 10,
  parameter  int INIT_Y   = 12,
  parameter  int WRAP     = 0,
  parameter  int TICK_DIV = 12_500_000,
  parameter  int SLOW_MUL = 2,
  localparam int XW       = coord_w(GRID_W),
  localparam int YW       = coord_w(GRID_H),
  localparam int LW       = coord_w(MAX_LEN + 1),
  localparam int IW       = coord_w(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              game_state,
  input  logic [1:0]              next_direction,
  input  logic                    pause,
  input  logic                    slow,
  input  logic [XW-1:0]           food_x,
  input  logic [YW-1:0]           food_y,
  output logic [MAX_LEN*XW-1:0]   snake_x_1dim,
  output logic [MAX_LEN*YW-1:0]   snake_y_1dim,
  output logic [LW-1:0]           snake_length,
  output logic [1:0]              current_direction,
  output logic                    get_food,
  output logic                    hit_boundary,
  output logic                    hit_self,
  output logic                    busy
);

  if (TICK_DIV <= MAX_LEN + 2) begin : g_bad_tick
    $error("snake_engine: TICK_DIV must exceed MAX_LEN+2");
  end
  if (INIT_LEN < 2 || INIT_LEN > MAX_LEN) begin : g_bad_len
    $error("snake_engine: INIT_LEN must be in 2..MAX_LEN");
  end

  state_e                     state_q, state_d;
  logic [MAX_LEN-1:0][XW-1:0] bx_q, bx_d;
  logic [MAX_LEN-1:0][YW-1:0] by_q, by_d;
  logic [LW-1:0]              len_q, len_d, len_mv;
  logic [1:0]                 dir_q, dir_d, ndir_q, ndir_d, dir_new;
  logic [XW-1:0]              cx_q, cx_d, hx_n;
  logic [YW-1:0]              cy_q, cy_d, hy_n;
  logic [IW-1:0]              idx_q, idx_d, idx_last;
  logic                       grow_q, grow_d, gf_q, gf_d, hb_q, hb_d, hs_q, hs_d;
  logic                       busy_q, busy_d, oob, tick, tick_en, init;

  assign init    = (game_state == GS_INITIAL);
  assign tick_en = (state_q == S_IDLE) && (game_state == GS_RUNNING) && !pause;

  snake_tick_gen #(.TICK_DIV(TICK_DIV), .SLOW_MUL(SLOW_MUL)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (init),
    .en_i   (tick_en),
    .slow_i (slow),
    .tick_o (tick)
  );

  // Candidate head from the live head and the filtered direction.
  always_comb begin
    dir_new = (next_direction == dir_reverse(dir_q)) ? dir_q : next_direction;
    hx_n    = bx_q[0];
    hy_n    = by_q[0];
    oob     = 1'b0;
    case (dir_new)
      DIR_UP:
        if (by_q[0] == '0) begin oob = 1'b1; hy_n = YW'(GRID_H - 1); end
        else hy_n = by_q[0] - YW'(1);
      DIR_DOWN:
        if (by_q[0] == YW'(GRID_H - 1)) begin oob = 1'b1; hy_n = '0; end
        else hy_n = by_q[0] + YW'(1);
      DIR_RIGHT:
        if (bx_q[0] == XW'(GRID_W - 1)) begin oob = 1'b1; hx_n = '0; end
        else hx_n = bx_q[0] + XW'(1);
      default:
        if (bx_q[0] == '0) begin oob = 1'b1; hx_n = XW'(GRID_W - 1); end
        else hx_n = bx_q[0] - XW'(1);
    endcase
  end

  // The tail cell is free to enter unless the snake is growing this step.
  assign idx_last = grow_q ? IW'(len_q - LW'(1)) : IW'(len_q - LW'(2));
  assign len_mv   = (grow_q && len_q != LW'(MAX_LEN)) ? len_q + LW'(1) : len_q;

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    len_d   = len_q;
    dir_d   = dir_q;
    ndir_d  = ndir_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    idx_d   = idx_q;
    grow_d  = grow_q;
    hb_d    = hb_q;
    hs_d    = hs_q;
    gf_d    = 1'b0;
    case (state_q)
      S_IDLE: if (tick) state_d = S_CALC;
      S_CALC: begin
        ndir_d = dir_new;
        cx_d   = hx_n;
        cy_d   = hy_n;
        grow_d = (hx_n == food_x) && (hy_n == food_y);
        idx_d  = '0;
        if (WRAP == 0 && oob) begin
          hb_d    = 1'b1;
          state_d = S_DEAD;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (bx_q[idx_q] == cx_q && by_q[idx_q] == cy_q) begin
          hs_d    = 1'b1;
          state_d = S_DEAD;
        end else if (idx_q == idx_last) begin
          state_d = S_MOVE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_MOVE: begin
        bx_d[0] = cx_q;
        by_d[0] = cy_q;
        // Cells past the new length stay zero, so a saturated grow drops the tail.
        for (int i = 1; i < MAX_LEN; i++) begin
          bx_d[i] = (LW'(i) < len_mv) ? bx_q[i-1] : '0;
          by_d[i] = (LW'(i) < len_mv) ? by_q[i-1] : '0;
        end
        len_d   = len_mv;
        dir_d   = ndir_q;
        gf_d    = grow_q;
        state_d = S_IDLE;
      end
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_SCAN) || (state_d == S_MOVE);
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      state_q <= S_IDLE;
      len_q   <= LW'(INIT_LEN);
      dir_q   <= DIR_RIGHT;
      ndir_q  <= DIR_RIGHT;
      cx_q    <= '0;
      cy_q    <= '0;
      idx_q   <= '0;
      grow_q  <= 1'b0;
      gf_q    <= 1'b0;
      hb_q    <= 1'b0;
      hs_q    <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        bx_q[i] <= (i < INIT_LEN) ? XW'(INIT_X - i) : '0;
        by_q[i] <= (i < INIT_LEN) ? YW'(INIT_Y) : '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      ndir_q  <= ndir_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      grow_q  <= grow_d;
      gf_q    <= gf_d;
      hb_q    <= hb_d;
      hs_q    <= hs_d;
      busy_q  <= busy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
    end
  end

  assign snake_x_1dim      = bx_q;
  assign snake_y_1dim      = by_q;
  assign snake_length      = len_q;
  assign current_direction = dir_q;
  assign get_food          = gf_q;
  assign hit_boundary      = hb_q;
  assign hit_self          = hs_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_snake_engine.sv
// Wall and wrap engines driven in lockstep against a queue-based step model.
module tb_snake_engine;

  localparam int MAXL = 5;
  localparam int CW   = 5;
  localparam int TD   = 8;

  logic       clk = 1'b0, rst = 1'b1, pause = 1'b0, slow = 1'b0;
  logic [1:0] gs = 2'd0, nd = 2'd2;
  logic [4:0] fx = 5'd31, fy = 5'd23;

  logic [MAXL*CW-1:0] sx[2], sy[2];
  logic [2:0]         slen[2];
  logic [1:0]         sdir[2];
  logic               gf[2], hb[2], hs[2], bz[2];

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  // Reference: body as queues (head first) plus an abstract step schedule.
  int qx[2][$], qy[2][$];
  int m_dir[2], m_cnt[2], m_age[2], m_fin[2], m_cx[2], m_cy[2], m_ndir[2];
  int m_steps[2] = '{0, 0};
  bit m_hb[2], m_hs[2], m_gf[2], m_dead[2], m_grow[2], m_self[2];

  always #5 clk = ~clk;

  snake_engine #(.MAX_LEN(MAXL), .TICK_DIV(TD), .WRAP(0)) u_wall (
    .clk(clk), .rst(rst), .game_state(gs), .next_direction(nd), .pause(pause), .slow(slow),
    .food_x(fx), .food_y(fy), .snake_x_1dim(sx[0]), .snake_y_1dim(sy[0]),
    .snake_length(slen[0]), .current_direction(sdir[0]), .get_food(gf[0]),
    .hit_boundary(hb[0]), .hit_self(hs[0]), .busy(bz[0]));

  snake_engine #(.MAX_LEN(MAXL), .TICK_DIV(TD), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .game_state(gs), .next_direction(nd), .pause(pause), .slow(slow),
    .food_x(fx), .food_y(fy), .snake_x_1dim(sx[1]), .snake_y_1dim(sy[1]),
    .snake_length(slen[1]), .current_direction(sdir[1]), .get_food(gf[1]),
    .hit_boundary(hb[1]), .hit_self(hs[1]), .busy(bz[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_init(input int k);
    qx[k].delete();
    qy[k].delete();
    for (int i = 0; i < 3; i++) begin
      qx[k].push_back(10 - i);
      qy[k].push_back(12);
    end
    m_dir[k] = 2; m_cnt[k] = 0; m_age[k] = -1;
    m_hb[k] = 0; m_hs[k] = 0; m_gf[k] = 0; m_dead[k] = 0;
  endtask

  // Age counts edges since the tick: decision at age 1, scan index i at
  // age 2+i, commit at age 2+(number of cells scanned).
  task automatic model_edge(input int k);
    int hx, hy, n, j;
    m_gf[k] = 0;
    if (rst || gs == 2'd2) begin model_init(k); return; end
    if (m_dead[k]) return;
    if (m_age[k] < 0) begin
      if (gs == 2'd0 && !pause) begin
        if (m_cnt[k] >= (slow ? TD * 2 : TD) - 1) begin m_cnt[k] = 0; m_age[k] = 0; end
        else m_cnt[k]++;
      end
      return;
    end
    m_age[k]++;
    if (m_age[k] == 1) begin
      m_ndir[k] = (int'(nd) == (m_dir[k] ^ 1)) ? m_dir[k] : int'(nd);
      hx = qx[k][0];
      hy = qy[k][0];
      case (m_ndir[k])
        0: hy--;
        1: hy++;
        2: hx++;
        default: hx--;
      endcase
      if (hx < 0 || hx >= 32 || hy < 0 || hy >= 24) begin
        if (k == 0) begin m_hb[k] = 1; m_dead[k] = 1; m_age[k] = -1; return; end
        hx = (hx + 32) % 32;
        hy = (hy + 24) % 24;
      end
      m_cx[k] = hx; m_cy[k] = hy;
      m_grow[k] = (hx == int'(fx)) && (hy == int'(fy));
      n = m_grow[k] ? qx[k].size() : qx[k].size() - 1;
      j = -1;
      for (int i = n - 1; i >= 0; i--) if (qx[k][i] == hx && qy[k][i] == hy) j = i;
      m_self[k] = (j >= 0);
      m_fin[k]  = m_self[k] ? 2 + j : 2 + n;
    end else if (m_age[k] == m_fin[k]) begin
      m_age[k] = -1;
      if (m_self[k]) begin
        m_hs[k] = 1; m_dead[k] = 1;
      end else begin
        qx[k].push_front(m_cx[k]);
        qy[k].push_front(m_cy[k]);
        if (!m_grow[k] || qx[k].size() > MAXL) begin
          void'(qx[k].pop_back());
          void'(qy[k].pop_back());
        end
        m_dir[k] = m_ndir[k];
        m_gf[k]  = m_grow[k];
        m_steps[k]++;
      end
    end
  endtask

  function automatic logic [63:0] pack_body(input int k, input bit yax);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < MAXL; i++)
      if (i < qx[k].size()) v[i*CW +: CW] = yax ? 5'(qy[k][i]) : 5'(qx[k][i]);
    return v;
  endfunction

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.body_x", k), 64'(sx[k]), pack_body(k, 0));
        chk($sformatf("u%0d.body_y", k), 64'(sy[k]), pack_body(k, 1));
        chk($sformatf("u%0d.length", k), 64'(slen[k]), 64'(qx[k].size()));
        chk($sformatf("u%0d.dir", k), 64'(sdir[k]), 64'(m_dir[k]));
        chk($sformatf("u%0d.get_food", k), 64'(gf[k]), 64'(m_gf[k]));
        chk($sformatf("u%0d.hit_boundary", k), 64'(hb[k]), 64'(m_hb[k]));
        chk($sformatf("u%0d.hit_self", k), 64'(hs[k]), 64'(m_hs[k]));
        chk($sformatf("u%0d.busy", k), 64'(bz[k]), 64'(m_age[k] >= 0));
      end
    end
  end

  task automatic do_step(input logic [1:0] d, input int k);
    int s, t;
    s = m_steps[k];
    t = 0;
    nd = d;
    while (m_steps[k] == s && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("step_timeout", 64'(t < 300), 64'(1));
  endtask

  task automatic restart();
    gs = 2'd2;
    @(negedge clk);
    gs = 2'd0;
  endtask

  initial begin
    int t;
    // Reset state
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_len", 64'(slen[0]), 64'(3));
    chk("rst_head_x", 64'(sx[0][4:0]), 64'(10));
    chk("rst_tail_x", 64'(sx[0][14:10]), 64'(8));
    chk("rst_head_y", 64'(sy[0][4:0]), 64'(12));
    chk("rst_dir", 64'(sdir[0]), 64'(2));
    chk("rst_busy", 64'(bz[0]), 64'(0));
    rst = 1'b0;

    // Straight run: commit exactly TD+4 edges after release
    repeat (11) @(negedge clk);
    chk("run_pre_head", 64'(sx[0][4:0]), 64'(10));
    @(negedge clk);
    chk("run_head", 64'(sx[0][4:0]), 64'(11));

    // Reverse rejection
    do_step(2'd3, 0);
    chk("rev_head", 64'(sx[0][4:0]), 64'(12));
    chk("rev_dir", 64'(sdir[0]), 64'(2));

    // Growth, then saturation at MAX_LEN
    fx = 5'd13; fy = 5'd12;
    do_step(2'd2, 0);
    chk("grow_pulse", 64'(gf[0]), 64'(1));
    chk("grow_len", 64'(slen[0]), 64'(4));
    chk("grow_tail", 64'(sx[0][19:15]), 64'(10));
    fx = 5'd14; do_step(2'd2, 0);
    fx = 5'd15; do_step(2'd2, 0);
    chk("sat_pulse", 64'(gf[0]), 64'(1));
    chk("sat_len", 64'(slen[0]), 64'(5));
    fx = 5'd31; fy = 5'd23;

    // Self-hit: length-5 loop turns into segment 3
    do_step(2'd1, 0);
    do_step(2'd3, 0);
    nd = 2'd0;
    repeat (30) @(negedge clk);
    chk("self_hit", 64'(hs[0]), 64'(1));
    chk("self_hit_wrap", 64'(hs[1]), 64'(1));

    // Tail chase at length 4: entering the vacating tail cell is legal
    restart();
    fx = 5'd11; fy = 5'd12;
    do_step(2'd2, 0);
    fx = 5'd31; fy = 5'd23;
    do_step(2'd1, 0);
    do_step(2'd3, 0);
    do_step(2'd0, 0);
    chk("chase_no_hit", 64'(hs[0]), 64'(0));
    chk("chase_head_x", 64'(sx[0][4:0]), 64'(10));

    // Walls: walk to (31,5), then step right once more
    restart();
    for (int i = 0; i < 7; i++) do_step(2'd0, 0);
    for (int i = 0; i < 21; i++) do_step(2'd2, 0);
    chk("wall_pre_x", 64'(sx[0][4:0]), 64'(31));
    do_step(2'd2, 1);
    chk("wall_hit", 64'(hb[0]), 64'(1));
    chk("wall_body_x", 64'(sx[0][4:0]), 64'(31));
    chk("wrap_no_hit", 64'(hb[1]), 64'(0));
    chk("wrap_head_x", 64'(sx[1][4:0]), 64'(0));
    chk("wrap_head_y", 64'(sy[1][4:0]), 64'(5));

    // rst in the middle of a scan
    restart();
    t = 0;
    while (m_age[0] != 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("scan_reached", 64'(bz[0]), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_len", 64'(slen[0]), 64'(3));
    chk("mid_rst_head", 64'(sx[0][4:0]), 64'(10));
    chk("mid_rst_busy", 64'(bz[0]), 64'(0));

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge clk);
      r     = $urandom_range(99);
      rst   = ($urandom_range(499) == 0);
      gs    = (r < 3) ? 2'd1 : (r < 4) ? 2'd2 : 2'd0;
      if (m_dead[0] && m_dead[1] && $urandom_range(9) == 0) gs = 2'd2;
      pause = ($urandom_range(9) == 0);
      if ($urandom_range(49) == 0) slow = ~slow;
      nd = 2'($urandom);
      if ($urandom_range(1) == 1) begin
        fx = 5'(qx[0][0] + (nd == 2'd2 ? 1 : 0) - (nd == 2'd3 ? 1 : 0));
        fy = 5'(qy[0][0] + (nd == 2'd1 ? 1 : 0) - (nd == 2'd0 ? 1 : 0));
      end else begin
        fx = 5'($urandom_range(31));
        fy = 5'($urandom_range(23));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
